add32_byteser: RTL and testbench

ADD32_BYTESER -- requirements
Module: add32_byteser

---
 rtl/add32_byteser.sv | 190 +++++++++++++++++++
 tb/tb_add32_byteser.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/add32_byteser.sv
// Byte-serial adder: accepts A, B and carry-in, then adds one byte per cycle
// (LSB first) through the gp8 lookahead unit and presents {cout, sum, ovf}.

// 8-bit group generate/propagate lookahead unit.
// cout_o[i] is the carry out of bit i (i.e. the carry into bit i+1).
module gp8 (
    input  logic [7:0] g_i,
    input  logic [7:0] p_i,
    input  logic       cin_i,
    output logic [6:0] cout_o,
    output logic       gout_o,
    output logic       pout_o
);
    logic [7:0] grp_g;
    logic [7:0] grp_p;

    // grp_g[i]/grp_p[i] cover bits [i:0]; each carry is then one AND-OR off cin.
    always_comb begin
        grp_g    = '0;
        grp_p    = '0;
        grp_g[0] = g_i[0];
        grp_p[0] = p_i[0];
        for (int i = 1; i < 8; i++) begin
            grp_g[i] = g_i[i] | (p_i[i] & grp_g[i-1]);
            grp_p[i] = p_i[i] & grp_p[i-1];
        end
    end

    always_comb begin
        cout_o = '0;
        for (int i = 0; i < 7; i++) begin
            cout_o[i] = grp_g[i] | (grp_p[i] & cin_i);
        end
    end

    assign gout_o = grp_g[7];
    assign pout_o = grp_p[7];
endmodule

module add32_byteser #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [8*NBYTES-1:0]   a,
    input  logic [8*NBYTES-1:0]   b,
    input  logic                  cin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [8*NBYTES-1:0]   sum,
    output logic                  cout,
    output logic                  ovf,
    output logic [1:0]            dbg_state_o
);
    localparam int W  = 8 * NBYTES;
    localparam int KW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [KW-1:0]   k_q;
    logic            carry_q;
    logic [W-1:0]    sum_q;
    logic            cout_q;
    logic            ovf_q;
    logic            in_ready_q;
    logic            out_valid_q;

    logic [7:0]      a_byte;
    logic [7:0]      b_byte;
    logic [7:0]      g;
    logic [7:0]      p;
    logic [6:0]      gp_c;
    logic            gp_gout;
    logic            gp_pout;
    logic [7:0]      c;
    logic [7:0]      sum_byte;
    logic            carry_d;
    logic            ovf_d;
    logic [W-1:0]    sum_d;
    logic            last_byte;

    // Select the operand byte addressed by the byte index.
    always_comb begin
        a_byte = '0;
        b_byte = '0;
        for (int j = 0; j < NBYTES; j++) begin
            if (k_q == KW'(j)) begin
                a_byte = a_q[8*j +: 8];
                b_byte = b_q[8*j +: 8];
            end
        end
    end

    assign g = a_byte & b_byte;
    assign p = a_byte ^ b_byte;

    gp8 u_gp8 (
        .g_i    (g),
        .p_i    (p),
        .cin_i  (carry_q),
        .cout_o (gp_c),
        .gout_o (gp_gout),
        .pout_o (gp_pout)
    );

    assign c         = {gp_c, carry_q};
    assign sum_byte  = p ^ c;
    assign carry_d   = gp_gout | (gp_pout & carry_q);
    assign ovf_d     = gp_c[6] ^ carry_d;
    assign last_byte = (k_q == KW'(NBYTES - 1));

    always_comb begin
        sum_d = sum_q;
        for (int j = 0; j < NBYTES; j++) begin
            if (k_q == KW'(j)) begin
                sum_d[8*j +: 8] = sum_byte;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            k_q         <= '0;
            carry_q     <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q        <= a;
                        b_q        <= b;
                        carry_q    <= cin;
                        k_q        <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= S_RUN;
                    end
                end
                S_RUN: begin
                    sum_q   <= sum_d;
                    carry_q <= carry_d;
                    if (last_byte) begin
                        cout_q      <= carry_d;
                        ovf_q       <= ovf_d;
                        k_q         <= '0;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        k_q <= k_q + KW'(1);
                    end
                end
                S_DONE: begin
                    // Returning to IDLE here means the next accept is a cycle later.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign sum         = sum_q;
    assign cout        = cout_q;
    assign ovf         = ovf_q;
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_add32_byteser.sv
// Bench for add32_byteser: directed corner cases plus randomized operands,
// checked by a queue-based scoreboard against a plain-arithmetic model.
module tb_add32_byteser;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        cin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic [1:0]  dbg_state;

    int total = 0;
    int bad = 0;
    bit rnd_ready = 1'b0;
    logic [33:0] exp_q[$];

    add32_byteser #(.NBYTES(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .cin         (cin),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .sum         (sum),
        .cout        (cout),
        .ovf         (ovf),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    // Reference: {ovf, cout, sum} from 33-bit arithmetic and the sign rule.
    function automatic logic [33:0] model(input logic [31:0] av, input logic [31:0] bv, input logic cv);
        logic [32:0] full;
        logic        o;
        full = {1'b0, av} + {1'b0, bv} + {32'd0, cv};
        o = (av[31] == bv[31]) && (full[31] != av[31]);
        return {o, full};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    // Drive one operand set; the expectation is queued on the accepting edge.
    task automatic send(input logic [31:0] av, input logic [31:0] bv, input logic cv, input int idle);
        bit accepted = 1'b0;
        repeat (idle) @(negedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        a = av;
        b = bv;
        cin = cv;
        for (int n = 0; n < 200; n++) begin
            if (in_ready) begin
                exp_q.push_back(model(av, bv, cv));
                accepted = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!accepted) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: in_ready never rose, expected 1");
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            a = $urandom;
            b = $urandom;
            cin = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic drain();
        int n;
        for (n = 0; n < 300; n++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
        end
    endtask

    // Monitor: every completed output handshake consumes one expectation.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got 0x%0h expected no result", {ovf, cout, sum});
            end else begin
                check("result", {30'd0, ovf, cout, sum}, {30'd0, exp_q.pop_front()});
            end
        end
    end

    always @(posedge clk) begin
        #2;
        if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        int cnt;
        logic [33:0] e;
        logic [31:0] ra;
        logic [31:0] rb;

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_in_ready", {63'd0, in_ready}, 64'd1);
        check("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("reset_outputs", {30'd0, ovf, cout, sum}, 64'd0);

        // 1 + 1 with latency measurement
        send(32'h0000_0001, 32'h0000_0001, 1'b0, 0);
        cnt = 0;
        while (cnt < 20) begin
            @(negedge clk);
            if (out_valid) break;
            cnt++;
        end
        check("latency", 64'(cnt), 64'd4);
        drain();

        // Carry ripple and overflow corners
        send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 0);
        drain();
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0);
        drain();
        send(32'h8000_0000, 32'h8000_0000, 1'b0, 0);
        drain();

        // DONE stall with inputs wiggling
        out_ready = 1'b0;
        send(32'hA5A5_0F0F, 32'h5A5A_F0F1, 1'b1, 0);
        e = model(32'hA5A5_0F0F, 32'h5A5A_F0F1, 1'b1);
        cnt = 0;
        while (cnt < 20 && !out_valid) begin
            @(negedge clk);
            cnt++;
        end
        for (int i = 0; i < 5; i++) begin
            check("stall_hold", {30'd0, ovf, cout, sum}, {30'd0, e});
            check("stall_in_ready", {62'd0, in_ready, out_valid}, 64'd1);
            in_valid = 1'b1;
            a = $urandom;
            b = $urandom;
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("release_idle", {62'd0, in_ready, out_valid}, 64'd2);
        check("retain_after_idle", {30'd0, ovf, cout, sum}, {30'd0, e});
        drain();

        // Reset during RUN while byte 2 is being processed
        send(32'hDEAD_BEEF, 32'h0123_4567, 1'b1, 0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        if (exp_q.size() != 0) void'(exp_q.pop_back());
        check("abort_in_ready", {63'd0, in_ready}, 64'd1);
        check("abort_out_valid", {63'd0, out_valid}, 64'd0);
        check("abort_sum", {32'd0, sum}, 64'd0);
        send(32'h1234_5678, 32'h1111_1111, 1'b0, 0);
        cnt = 0;
        while (cnt < 20 && !out_valid) begin
            @(negedge clk);
            cnt++;
        end
        check("post_abort_sum", {32'd0, sum}, 64'h2345_6789);
        drain();

        // Randomized operands with input and output stalls
        rnd_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            case ($urandom_range(0, 7))
                0: ra = 32'hFFFF_FFFF;
                1: ra = 32'h7FFF_FFFF;
                2: ra = 32'h8000_0000;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0: rb = 32'h0000_0000;
                1: rb = 32'h8000_0000;
                2: rb = ~ra;
                default: rb = $urandom;
            endcase
            send(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end
        @(negedge clk);
        rnd_ready = 1'b0;
        @(posedge clk);
        #3;
        out_ready = 1'b1;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
